// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, op encoding
// and mstatus field layout.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH  = 12'hB80;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  // MPP=11 is the only machine-mode value; MIE/MPIE start cleared.
  localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;

endpackage

// File: rtl/csr_if.sv
// Bundle of CSR instruction, trap/mret and redirect-target signals between
// the core pipeline (master) and the CSR file (slave).
interface csr_if #(
  parameter int unsigned XLEN = 32
);

  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic            csr_src_zero;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic            trap_en;
  logic [XLEN-1:0] trap_cause;
  logic [XLEN-1:0] trap_epc;
  logic            mret_en;
  logic [XLEN-1:0] mtvec_o;
  logic [XLEN-1:0] mepc_o;
  logic            mie_o;

  modport master (
    output csr_op, csr_addr, csr_wdata, csr_src_zero,
    output trap_en, trap_cause, trap_epc, mret_en,
    input  csr_rdata, csr_illegal, mtvec_o, mepc_o, mie_o
  );

  modport slave (
    input  csr_op, csr_addr, csr_wdata, csr_src_zero,
    input  trap_en, trap_cause, trap_epc, mret_en,
    output csr_rdata, csr_illegal, mtvec_o, mepc_o, mie_o
  );

endinterface

// File: rtl/csr_mcycle.sv
// Free-running 64-bit cycle counter; a write to either half replaces that
// half and suppresses the increment for that cycle.
module csr_mcycle #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_lo,
  input  logic            wr_hi,
  input  logic [XLEN-1:0] wdata,
  output logic [63:0]     count
);

  // For XLEN=64 the low "half" spans the whole counter.
  always_ff @(posedge clk) begin : cnt_reg
    if (!rst_n) begin
      count <= '0;
    end else if (wr_lo) begin
      count[XLEN-1:0] <= wdata;
    end else if (wr_hi) begin
      count[63:32] <= wdata[31:0];
    end else begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: Zicsr RW/RS/RC, trap entry and mret.
// Optional mcycle/mcycleh counter enabled by defining CSR_MCYCLE_EN.
module csr_unit
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
  input logic    clk,
  input logic    rst_n,
  csr_if.slave   bus
);

  csr_op_e         op;
  logic            mie_q;
  logic            mpie_q;
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mscratch_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mstatus_rd;
  logic [XLEN-1:0] rdata_c;
  logic [XLEN-1:0] new_val;
  logic            impl;
  logic            wr_en;

`ifdef CSR_MCYCLE_EN
  localparam bit HAS_MCYCLEH = (XLEN == 32);
  logic [63:0] mcycle_cnt;
  logic        mcycle_wr_lo;
  logic        mcycle_wr_hi;
`endif

  assign op = csr_op_e'(bus.csr_op);

  // Address decode and combinational read of the pre-edge value.
  always_comb begin : read_mux
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = MSTATUS_RST[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
    mstatus_rd[MSTATUS_MIE]  = mie_q;
    mstatus_rd[MSTATUS_MPIE] = mpie_q;
    impl    = 1'b1;
    rdata_c = '0;
    case (bus.csr_addr)
      CSR_MSTATUS:  rdata_c = mstatus_rd;
      CSR_MTVEC:    rdata_c = mtvec_q;
      CSR_MSCRATCH: rdata_c = mscratch_q;
      CSR_MEPC:     rdata_c = mepc_q;
      CSR_MCAUSE:   rdata_c = mcause_q;
`ifdef CSR_MCYCLE_EN
      CSR_MCYCLE:   rdata_c = mcycle_cnt[XLEN-1:0];
      CSR_MCYCLEH: begin
        impl = HAS_MCYCLEH;
        if (HAS_MCYCLEH) rdata_c = XLEN'(mcycle_cnt[63:32]);
      end
`endif
      default:      impl = 1'b0;
    endcase
  end

  // Read-modify-write value and commit qualifier; a trap cancels the write.
  always_comb begin : write_data
    new_val = rdata_c;
    case (op)
      CSR_OP_RW: new_val = bus.csr_wdata;
      CSR_OP_RS: new_val = rdata_c | bus.csr_wdata;
      CSR_OP_RC: new_val = rdata_c & ~bus.csr_wdata;
      default:   new_val = rdata_c;
    endcase
    wr_en = (op != CSR_OP_NONE) && impl && !bus.trap_en &&
            !(((op == CSR_OP_RS) || (op == CSR_OP_RC)) && bus.csr_src_zero);
  end

  assign bus.csr_rdata   = rdata_c;
  assign bus.csr_illegal = (op != CSR_OP_NONE) && !impl;
  assign bus.mtvec_o     = mtvec_q;
  assign bus.mepc_o      = mepc_q;
  assign bus.mie_o       = mie_q;

  // State update: reset > trap > mret (owns mstatus) > instruction write.
  always_ff @(posedge clk) begin : csr_regs
    if (!rst_n) begin
      mie_q      <= MSTATUS_RST[MSTATUS_MIE];
      mpie_q     <= MSTATUS_RST[MSTATUS_MPIE];
      mtvec_q    <= {MTVEC_RST[XLEN-1:2], 2'b00};
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (bus.trap_en) begin
      mepc_q   <= {bus.trap_epc[XLEN-1:2], 2'b00};
      mcause_q <= bus.trap_cause;
      mpie_q   <= mie_q;
      mie_q    <= 1'b0;
    end else begin
      if (bus.mret_en) begin
        mie_q  <= mpie_q;
        mpie_q <= 1'b1;
      end else if (wr_en && (bus.csr_addr == CSR_MSTATUS)) begin
        mie_q  <= new_val[MSTATUS_MIE];
        mpie_q <= new_val[MSTATUS_MPIE];
      end
      if (wr_en) begin
        case (bus.csr_addr)
          CSR_MTVEC:    mtvec_q    <= {new_val[XLEN-1:2], 2'b00};
          CSR_MSCRATCH: mscratch_q <= new_val;
          CSR_MEPC:     mepc_q     <= {new_val[XLEN-1:2], 2'b00};
          CSR_MCAUSE:   mcause_q   <= new_val;
          default:      ;
        endcase
      end
    end
  end

`ifdef CSR_MCYCLE_EN
  assign mcycle_wr_lo = wr_en && (bus.csr_addr == CSR_MCYCLE);
  assign mcycle_wr_hi = wr_en && (bus.csr_addr == CSR_MCYCLEH);

  csr_mcycle #(.XLEN(XLEN)) u_mcycle (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_lo (mcycle_wr_lo),
    .wr_hi (mcycle_wr_hi),
    .wdata (new_val),
    .count (mcycle_cnt)
  );
`endif

endmodule

// File: tb/tb_csr_unit.sv
// Self-checking bench for csr_unit (XLEN=32) against a value-level model
// of the CSR file; covers the mcycle counter when CSR_MCYCLE_EN is defined.
module tb_csr_unit;

  localparam logic [31:0] TB_MTVEC_RST = 32'h2000_0107;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;
  logic [63:0] m_cycle;
  logic [31:0] obs_rd, exp_rd;
  logic        obs_ill, exp_ill;
  logic [11:0] addrs [5] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342};
  logic [11:0] pool  [8] = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                             12'hB00, 12'hB80, 12'h7C0};

  csr_if #(.XLEN(32)) bus ();

  csr_unit #(.XLEN(32), .MTVEC_RST(TB_MTVEC_RST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit implemented(input logic [11:0] a);
    case (a)
      12'h300, 12'h305, 12'h340, 12'h341, 12'h342: return 1'b1;
`ifdef CSR_MCYCLE_EN
      12'hB00, 12'hB80: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    if (!implemented(a)) return 32'h0;
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h340: return m_mscratch;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00: return m_cycle[31:0];
      12'hB80: return m_cycle[63:32];
      default: return 32'h0;
    endcase
  endfunction

  // One clock: drive at negedge, sample combinational read, advance model at posedge.
  task automatic step(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                      input bit sz, input bit trap, input logic [31:0] cause,
                      input logic [31:0] epc, input bit mret);
    logic [31:0] old, nv;
    bit legal, cyc_wr;
    @(negedge clk);
    bus.csr_op = op; bus.csr_addr = addr; bus.csr_wdata = wd; bus.csr_src_zero = sz;
    bus.trap_en = trap; bus.trap_cause = cause; bus.trap_epc = epc; bus.mret_en = mret;
    #1;
    obs_rd  = bus.csr_rdata;
    obs_ill = bus.csr_illegal;
    exp_rd  = model_read(addr);
    exp_ill = (op != 2'b00) && !implemented(addr);
    @(posedge clk);
    cyc_wr = 1'b0;
    if (!rst_n) begin
      m_mstatus = 32'h1800; m_mtvec = TB_MTVEC_RST & ~32'h3;
      m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cycle = 0; cyc_wr = 1'b1;
    end else if (trap) begin
      m_mstatus = 32'h1800 | (m_mstatus[3] ? 32'h80 : 32'h0);
      m_mepc = epc & ~32'h3;
      m_mcause = cause;
    end else begin
      old = model_read(addr);
      case (op)
        2'b01:   nv = wd;
        2'b10:   nv = old | wd;
        2'b11:   nv = old & ~wd;
        default: nv = old;
      endcase
      legal = (op != 2'b00) && implemented(addr) && !((op != 2'b01) && sz);
      if (mret) m_mstatus = 32'h1880 | (m_mstatus[7] ? 32'h8 : 32'h0);
      if (legal) begin
        case (addr)
          12'h300: if (!mret) m_mstatus = 32'h1800 | (nv & 32'h88);
          12'h305: m_mtvec = nv & ~32'h3;
          12'h340: m_mscratch = nv;
          12'h341: m_mepc = nv & ~32'h3;
          12'h342: m_mcause = nv;
          12'hB00: begin m_cycle[31:0]  = nv; cyc_wr = 1'b1; end
          12'hB80: begin m_cycle[63:32] = nv; cyc_wr = 1'b1; end
          default: ;
        endcase
      end
    end
    if (!cyc_wr) m_cycle = m_cycle + 64'd1;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] rv;
    rst_n = 1'b0;
    step(2'b00, 12'h300, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst_n = 1'b1;
    n_checks++; if (bus.mtvec_o !== 32'h2000_0104) begin n_errors++; $display("FAIL reset_mtvec_o: got %h expected %h", bus.mtvec_o, 32'h2000_0104); end
    n_checks++; if (bus.mepc_o !== 32'h0) begin n_errors++; $display("FAIL reset_mepc_o: got %h expected 0", bus.mepc_o); end
    n_checks++; if (bus.mie_o !== 1'b0) begin n_errors++; $display("FAIL reset_mie_o: got %b expected 0", bus.mie_o); end
    for (int i = 0; i < 5; i++) begin
      rv = (addrs[i] == 12'h300) ? 32'h1800 : (addrs[i] == 12'h305) ? 32'h2000_0104 : 32'h0;
      for (int o = 3; o >= 1; o--) begin
        step(2'(o), addrs[i], (o == 1) ? rv : 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        n_checks++; if (obs_rd !== rv) begin n_errors++; $display("FAIL reset_read %h op%0d: got %h expected %h", addrs[i], o, obs_rd, rv); end
        n_checks++; if (obs_ill !== 1'b0) begin n_errors++; $display("FAIL reset_illegal %h op%0d: got %b expected 0", addrs[i], o, obs_ill); end
      end
    end
  endtask

  task automatic test_rw_masks();
    step(2'b01, 12'h305, 32'h8000_0103, 1'b0, 1'b0, 0, 0, 1'b0);
    step(2'b00, 12'h305, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (obs_rd !== 32'h8000_0100) begin n_errors++; $display("FAIL mtvec_mask: got %h expected %h", obs_rd, 32'h8000_0100); end
    n_checks++; if (bus.mtvec_o !== 32'h8000_0100) begin n_errors++; $display("FAIL mtvec_o: got %h expected %h", bus.mtvec_o, 32'h8000_0100); end
    step(2'b01, 12'h340, 32'hFF, 1'b0, 1'b0, 0, 0, 1'b0);
    step(2'b10, 12'h340, 32'hF0, 1'b1, 1'b0, 0, 0, 1'b0);
    step(2'b00, 12'h340, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (obs_rd !== 32'hFF) begin n_errors++; $display("FAIL rs_src_zero: got %h expected %h", obs_rd, 32'hFF); end
    step(2'b11, 12'h340, 32'h0F, 1'b0, 1'b0, 0, 0, 1'b0);
    step(2'b00, 12'h340, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (obs_rd !== 32'hF0) begin n_errors++; $display("FAIL rc_clear: got %h expected %h", obs_rd, 32'hF0); end
    step(2'b01, 12'h300, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 0, 1'b0);
    step(2'b00, 12'h300, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (obs_rd !== 32'h1888) begin n_errors++; $display("FAIL mstatus_mask: got %h expected %h", obs_rd, 32'h1888); end
    step(2'b01, 12'h300, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    step(2'b01, 12'h341, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 0, 1'b0);
    step(2'b00, 12'h341, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (obs_rd !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL mepc_mask: got %h expected %h", obs_rd, 32'hFFFF_FFFC); end
    n_checks++; if (bus.mepc_o !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL mepc_o: got %h expected %h", bus.mepc_o, 32'hFFFF_FFFC); end
  endtask

  task automatic test_trap_mret();
    step(2'b01, 12'h300, 32'h8, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (bus.mie_o !== 1'b1) begin n_errors++; $display("FAIL set_mie: got %b expected 1", bus.mie_o); end
    step(2'b00, 12'h342, 32'h0, 1'b0, 1'b1, 32'd11, 32'h8000_0042, 1'b0);
    n_checks++; if (bus.mepc_o !== 32'h8000_0040) begin n_errors++; $display("FAIL trap_mepc: got %h expected %h", bus.mepc_o, 32'h8000_0040); end
    n_checks++; if (bus.mie_o !== 1'b0) begin n_errors++; $display("FAIL trap_mie: got %b expected 0", bus.mie_o); end
    step(2'b00, 12'h300, 32'h0, 1'b0, 1'b0, 0, 0, 1'b1);
    n_checks++; if (obs_rd !== 32'h1880) begin n_errors++; $display("FAIL trap_mstatus: got %h expected %h", obs_rd, 32'h1880); end
    n_checks++; if (bus.mie_o !== 1'b1) begin n_errors++; $display("FAIL mret_mie: got %b expected 1", bus.mie_o); end
    step(2'b00, 12'h342, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (obs_rd !== 32'd11) begin n_errors++; $display("FAIL trap_mcause: got %h expected %h", obs_rd, 32'd11); end
    step(2'b00, 12'h300, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (obs_rd !== 32'h1888) begin n_errors++; $display("FAIL mret_mstatus: got %h expected %h", obs_rd, 32'h1888); end
  endtask

  task automatic test_priority();
    step(2'b01, 12'h300, 32'h8, 1'b0, 1'b0, 0, 0, 1'b0);
    step(2'b01, 12'h300, 32'h8, 1'b0, 1'b1, 32'd2, 32'h0000_0104, 1'b1);
    n_checks++; if (bus.mie_o !== 1'b0) begin n_errors++; $display("FAIL prio_trap_mie: got %b expected 0", bus.mie_o); end
    n_checks++; if (bus.mepc_o !== 32'h104) begin n_errors++; $display("FAIL prio_trap_mepc: got %h expected %h", bus.mepc_o, 32'h104); end
    step(2'b00, 12'h300, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (obs_rd !== 32'h1880) begin n_errors++; $display("FAIL prio_trap_mstatus: got %h expected %h", obs_rd, 32'h1880); end
    step(2'b00, 12'h342, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (obs_rd !== 32'd2) begin n_errors++; $display("FAIL prio_trap_mcause: got %h expected 2", obs_rd); end
    step(2'b01, 12'h300, 32'h0, 1'b0, 1'b0, 0, 0, 1'b1);
    step(2'b01, 12'h340, 32'h55, 1'b0, 1'b0, 0, 0, 1'b1);
    step(2'b00, 12'h300, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (obs_rd !== 32'h1888) begin n_errors++; $display("FAIL prio_mret_mstatus: got %h expected %h", obs_rd, 32'h1888); end
    step(2'b00, 12'h340, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (obs_rd !== 32'h55) begin n_errors++; $display("FAIL prio_mret_mscratch: got %h expected %h", obs_rd, 32'h55); end
  endtask

  task automatic test_illegal();
    step(2'b01, 12'h7C0, 32'h1, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (obs_ill !== 1'b1) begin n_errors++; $display("FAIL illegal_flag: got %b expected 1", obs_ill); end
    n_checks++; if (obs_rd !== 32'h0) begin n_errors++; $display("FAIL illegal_rdata: got %h expected 0", obs_rd); end
    step(2'b00, 12'h7C0, 32'h1, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (obs_ill !== 1'b0) begin n_errors++; $display("FAIL illegal_noop: got %b expected 0", obs_ill); end
`ifndef CSR_MCYCLE_EN
    step(2'b01, 12'hB00, 32'h1, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (obs_ill !== 1'b1 || obs_rd !== 32'h0) begin n_errors++; $display("FAIL illegal_mcycle: got ill=%b rd=%h expected ill=1 rd=0", obs_ill, obs_rd); end
    step(2'b10, 12'hB80, 32'h1, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (obs_ill !== 1'b1 || obs_rd !== 32'h0) begin n_errors++; $display("FAIL illegal_mcycleh: got ill=%b rd=%h expected ill=1 rd=0", obs_ill, obs_rd); end
`endif
    for (int i = 0; i < 5; i++) begin
      step(2'b00, addrs[i], 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
      n_checks++; if (obs_rd !== exp_rd) begin n_errors++; $display("FAIL illegal_nochange %h: got %h expected %h", addrs[i], obs_rd, exp_rd); end
    end
  endtask

`ifdef CSR_MCYCLE_EN
  task automatic test_mcycle();
    logic [31:0] h, l;
    step(2'b01, 12'hB00, 32'hFFFF_FFFE, 1'b0, 1'b0, 0, 0, 1'b0);
    step(2'b00, 12'hB00, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (obs_rd !== 32'hFFFF_FFFE) begin n_errors++; $display("FAIL mcycle_write: got %h expected %h", obs_rd, 32'hFFFF_FFFE); end
    step(2'b00, 12'hB80, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    h = obs_rd;
    n_checks++; if (obs_rd !== exp_rd) begin n_errors++; $display("FAIL mcycleh_read: got %h expected %h", obs_rd, exp_rd); end
    step(2'b00, 12'hB80, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (obs_rd !== h + 32'd1) begin n_errors++; $display("FAIL mcycle_carry: got %h expected %h", obs_rd, h + 32'd1); end
    step(2'b00, 12'hB00, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    l = obs_rd;
    step(2'b01, 12'hB80, 32'h1234, 1'b0, 1'b0, 0, 0, 1'b0);
    step(2'b00, 12'hB00, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (obs_rd !== l + 32'd1) begin n_errors++; $display("FAIL mcycle_hold_lo: got %h expected %h", obs_rd, l + 32'd1); end
    step(2'b00, 12'hB80, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (obs_rd !== 32'h1234) begin n_errors++; $display("FAIL mcycleh_write: got %h expected %h", obs_rd, 32'h1234); end
    step(2'b01, 12'hB80, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 0, 1'b0);
    step(2'b01, 12'hB00, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 0, 1'b0);
    step(2'b00, 12'hB80, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (obs_rd !== 32'hFFFF_FFFF) begin n_errors++; $display("FAIL mcycle_allones: got %h expected %h", obs_rd, 32'hFFFF_FFFF); end
    step(2'b00, 12'hB80, 32'h0, 1'b0, 1'b0, 0, 0, 1'b0);
    n_checks++; if (obs_rd !== 32'h0) begin n_errors++; $display("FAIL mcycle_wrap: got %h expected 0", obs_rd); end
  endtask
`endif

  task automatic test_random();
    logic [11:0] a;
    logic [31:0] wd;
    for (int n = 0; n < 400; n++) begin
      a  = pool[$urandom_range(0, 7)];
      wd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      step(2'($urandom_range(0, 3)), a, wd, ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 7) == 0), $urandom, $urandom, ($urandom_range(0, 5) == 0));
      n_checks++; if (obs_rd !== exp_rd) begin n_errors++; $display("FAIL rand_rdata %h: got %h expected %h", a, obs_rd, exp_rd); end
      n_checks++; if (obs_ill !== exp_ill) begin n_errors++; $display("FAIL rand_illegal %h: got %b expected %b", a, obs_ill, exp_ill); end
      n_checks++; if (bus.mtvec_o !== m_mtvec) begin n_errors++; $display("FAIL rand_mtvec_o: got %h expected %h", bus.mtvec_o, m_mtvec); end
      n_checks++; if (bus.mepc_o !== m_mepc) begin n_errors++; $display("FAIL rand_mepc_o: got %h expected %h", bus.mepc_o, m_mepc); end
      n_checks++; if (bus.mie_o !== m_mstatus[3]) begin n_errors++; $display("FAIL rand_mie_o: got %b expected %b", bus.mie_o, m_mstatus[3]); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.csr_op = 2'b00; bus.csr_addr = 12'h0; bus.csr_wdata = 32'h0; bus.csr_src_zero = 1'b0;
    bus.trap_en = 1'b0; bus.trap_cause = 32'h0; bus.trap_epc = 32'h0; bus.mret_en = 1'b0;
    m_mstatus = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cycle = 0;
    test_reset();
    test_rw_masks();
    test_trap_mret();
    test_priority();
    test_illegal();
`ifdef CSR_MCYCLE_EN
    test_mcycle();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
Name: csr_unit

Overview:
Machine-mode CSR file for the single-cycle core, parametrised in XLEN. Executes Zicsr read-modify-write ops (RW/RS/RC), trap entry (ecall and other exceptions) and mret return. Supplies the redirect targets mtvec and mepc to the PC logic. Sits between decode/EXU and the next-PC mux; the exception source provides cause and epc.

Parameters:
XLEN, 32, data width of all CSRs and data ports (32 or 64)
MTVEC_RST, 0, reset value of mtvec (bits[1:0] forced to 00)

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC
csr_addr  in  12  CSR address for read and write
csr_wdata  in  XLEN  rs1 value or zero-extended uimm
csr_src_zero  in  1  rs1/uimm field is x0/0; suppresses the write for RS/RC
csr_rdata  out  XLEN  old value of the addressed CSR (combinational)
csr_illegal  out  1  csr_op!=00 and the address is unimplemented
trap_en  in  1  take a trap this cycle
trap_cause  in  XLEN  value written to mcause
trap_epc  in  XLEN  PC of the trapping instruction
mret_en  in  1  execute mret this cycle
mtvec_o  out  XLEN  trap target
mepc_o  out  XLEN  mret target
mie_o  out  1  mstatus.MIE

Behaviour:
- Implemented CSRs: mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342.
- Reset (rst_n=0 at posedge): mstatus=0x1800, mtvec=MTVEC_RST&~3, mscratch=0, mepc=0, mcause=0. Outputs follow immediately after that edge. Reset overrides every other input.
- Read path is combinational. csr_rdata = current value, or 0 if the address is unimplemented. A same-cycle write is visible only from the next cycle.
- New value: RW=wdata, RS=old|wdata, RC=old&~wdata. It is committed at posedge when csr_op!=00 and !csr_illegal and !(op in {RS,RC} && csr_src_zero).
- Write masks:
  - mstatus: only MIE[3] and MPIE[7] are writable. MPP[12:11] reads as 11 always (WARL). All other bits read 0.
  - mtvec[1:0] is forced to 00 (direct mode only).
  - mepc[1:0] is forced to 00.
  - mscratch and mcause are fully writable.
- Illegal address: no state change. csr_illegal=1 in the same cycle.
- Trap (trap_en=1) at posedge:
  - mepc = trap_epc with [1:0] cleared; mcause = trap_cause.
  - MPIE = MIE; MIE = 0; MPP = 11.
- mret (mret_en=1) at posedge: MIE = MPIE; MPIE = 1; MPP = 11.
- Priority when events coincide: reset > trap > mret > CSR instruction write.
  - A trap discards a same-cycle mret and CSR write entirely.
  - mret discards a same-cycle CSR write to mstatus only; writes to other CSRs still commit.
- mtvec_o, mepc_o and mie_o are direct register outputs with no added latency.

Optional Feature:
Macro CSR_MCYCLE_EN.
- Defined:
  - A 64-bit mcycle counter at 0xB00. For XLEN=32, the upper half is at 0xB80; for XLEN=64, 0xB80 is illegal.
  - Resets to 0 and increments every cycle.
  - A CSR write to either half replaces that half; the counter does not increment in that cycle, and the other half is held.
  - The low half wraps into the high half with carry. All-ones wraps to 0.
- Undefined: 0xB00 and 0xB80 are unimplemented (illegal, read 0) and no counter flops exist.

Decomposition:
- Shared package csr_pkg holds:
  - CSR address constants;
  - csr_op encoding;
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11);
  - the mstatus reset constant 0x1800.
- One sub-module, csr_mcycle: the 64-bit counter with half-write ports. It is instantiated only under CSR_MCYCLE_EN.

Test Plan:
1. Reset, then read every CSR -> mstatus=0x1800, all others 0; csr_illegal=0 for each op.
2. RW 0x305 with 0x8000_0103, then read -> 0x8000_0100. RS 0x340 with 0xF0 and csr_src_zero=1 -> mscratch unchanged. RC 0x340 with 0x0F after RW 0xFF -> 0xF0.
3. Set MIE=1, then trap_en with cause=11 and epc=0x8000_0042 -> mepc=0x8000_0040, mcause=11, mstatus=0x1880. mret_en next cycle -> mstatus=0x1888.
4. trap_en, mret_en and RW mstatus=0x8 in the same cycle -> only trap effects appear; the mstatus write is lost.
5. Op RW to 0x7C0 with wdata 0x1 -> csr_illegal=1, csr_rdata=0, no CSR changes.
6. (CSR_MCYCLE_EN, XLEN=32) RW 0xB00=0xFFFF_FFFE -> reads 0xFFFF_FFFE the following cycle, then 0xB80 increments by 1 two cycles later. A write to 0xB80 holds the low half for that cycle.
